// File: rtl/usb_bus_ctrl.sv
// Low-speed USB device bus-state controller: tracks active/suspend/resume/bus-reset
// from the PHY line state and drives remote-wakeup K when the host has enabled it.
module usb_bus_ctrl #(
    parameter int unsigned CLK_HZ         = 24_000_000,
    parameter int unsigned SUSPEND_US     = 3000,
    parameter int unsigned WAKEUP_IDLE_US = 5000,
    parameter int unsigned RESUME_K_US    = 10000
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [1:0] line_state,
    input  logic       usb_reset_i,
    input  logic       wakeup_req_i,
    input  logic       wakeup_en_i,
    output logic       suspend_o,
    output logic       resume_o,
    output logic       bus_reset_o,
    output logic       tx_oe_o,
    output logic       tx_k_o,
    output logic [2:0] state_o
);

    localparam longint unsigned SUSPEND_CYC  = (64'(CLK_HZ) * 64'(SUSPEND_US)) / 64'd1_000_000;
    localparam longint unsigned WAKEUP_CYC   = (64'(CLK_HZ) * 64'(WAKEUP_IDLE_US)) / 64'd1_000_000;
    localparam longint unsigned RESUME_K_CYC = (64'(CLK_HZ) * 64'(RESUME_K_US)) / 64'd1_000_000;

    localparam longint unsigned MAX_AB  = (SUSPEND_CYC > WAKEUP_CYC) ? SUSPEND_CYC : WAKEUP_CYC;
    localparam longint unsigned MAX_CYC = (MAX_AB > RESUME_K_CYC) ? MAX_AB : RESUME_K_CYC;
    localparam int              CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SUSPEND_LAST = CNT_W'(SUSPEND_CYC - 1);
    localparam logic [CNT_W-1:0] WAKEUP_CNT   = CNT_W'(WAKEUP_CYC);
    localparam logic [CNT_W-1:0] RESUME_LAST  = CNT_W'(RESUME_K_CYC - 1);

    // Logical line states as delivered by the PHY; SE1 is simply "not J, not K".
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;

    typedef enum logic [2:0] {
        ST_ACTIVE       = 3'd0,
        ST_SUSPENDED    = 3'd1,
        ST_WAKEUP_WAIT  = 3'd2,
        ST_WAKEUP_DRIVE = 3'd3,
        ST_RESUMING     = 3'd4,
        ST_BUS_RESET    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             se0_seen_q, se0_seen_d;
    logic             suspend_q, suspend_d;
    logic             resume_q, resume_d;
    logic             bus_reset_q, bus_reset_d;
    logic             tx_oe_q, tx_oe_d;
    logic             tx_k_q, tx_k_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        se0_seen_d = se0_seen_q;
        resume_d   = 1'b0;

        case (state_q)
            ST_ACTIVE: begin
                if (line_state == LS_J) begin
                    if (cnt_q == SUSPEND_LAST) begin
                        state_d = ST_SUSPENDED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            // The reserved wait encoding behaves exactly like SUSPENDED.
            ST_SUSPENDED, ST_WAKEUP_WAIT: begin
                if (line_state == LS_K) begin
                    state_d    = ST_RESUMING;
                    cnt_d      = '0;
                    pending_d  = 1'b0;
                    se0_seen_d = 1'b0;
                end else if (pending_q && (cnt_q >= WAKEUP_CNT) && (line_state == LS_J)) begin
                    state_d   = ST_WAKEUP_DRIVE;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    if (cnt_q < WAKEUP_CNT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (wakeup_req_i && wakeup_en_i) begin
                        pending_d = 1'b1;
                    end
                end
            end

            ST_WAKEUP_DRIVE: begin
                if (cnt_q == RESUME_LAST) begin
                    state_d    = ST_RESUMING;
                    cnt_d      = '0;
                    se0_seen_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Host ends resume with an EOP: only a J after SE0 counts.
            ST_RESUMING: begin
                if (line_state == LS_SE0) begin
                    se0_seen_d = 1'b1;
                end else if ((line_state == LS_J) && se0_seen_q) begin
                    state_d    = ST_ACTIVE;
                    cnt_d      = '0;
                    se0_seen_d = 1'b0;
                    resume_d   = 1'b1;
                end
            end

            ST_BUS_RESET: begin
                if (!usb_reset_i) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_ACTIVE;
                cnt_d   = '0;
            end
        endcase

        if (usb_reset_i) begin
            state_d    = ST_BUS_RESET;
            cnt_d      = '0;
            pending_d  = 1'b0;
            se0_seen_d = 1'b0;
            resume_d   = 1'b0;
        end

        // Outputs are decoded from the next state so they change with the state flop.
        suspend_d   = (state_d == ST_SUSPENDED) || (state_d == ST_WAKEUP_WAIT);
        tx_oe_d     = (state_d == ST_WAKEUP_DRIVE);
        tx_k_d      = (state_d == ST_WAKEUP_DRIVE);
        bus_reset_d = (state_d == ST_BUS_RESET) && (state_q != ST_BUS_RESET);
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_ACTIVE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            se0_seen_q  <= 1'b0;
            suspend_q   <= 1'b0;
            resume_q    <= 1'b0;
            bus_reset_q <= 1'b0;
            tx_oe_q     <= 1'b0;
            tx_k_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            se0_seen_q  <= se0_seen_d;
            suspend_q   <= suspend_d;
            resume_q    <= resume_d;
            bus_reset_q <= bus_reset_d;
            tx_oe_q     <= tx_oe_d;
            tx_k_q      <= tx_k_d;
        end
    end

    assign suspend_o   = suspend_q;
    assign resume_o    = resume_q;
    assign bus_reset_o = bus_reset_q;
    assign tx_oe_o     = tx_oe_q;
    assign tx_k_o      = tx_k_q;
    assign state_o     = state_q;

endmodule
